// File: rtl/elastic_pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline.
package elastic_pipe_pkg;

  localparam int   DEFAULT_WIDTH     = 32'sd32;
  localparam int   DEFAULT_DEPTH     = 32'sd2;
  localparam logic DEFAULT_FLUSH_BIT = 1'b0;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 32'sd0;
    span   = 32'sd1;
    while (span < value) begin
      span   = span * 32'sd2;
      result = result + 32'sd1;
    end
    return result;
  endfunction

  // Occupancy spans 0..2*depth inclusive.
  function automatic int occ_width(input int depth);
    return clog2(32'sd2 * depth + 32'sd1);
  endfunction

endpackage

// File: rtl/elastic_pipe_skid_stage.sv
// One two-entry skid stage; ready comes straight from a flop so stages never
// form a combinational ready chain.
module skid_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       cnt_d
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             accept_s;
  logic             drain_s;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign accept_s  = in_valid & ~skid_valid_q;
  assign drain_s   = ~main_valid_q | out_ready;

  // Next-state for main/skid entries; skid is only ever filled while main stalls.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain_s && skid_valid_q) begin
      main_valid_d = 1'b1;
      main_data_d  = skid_data_q;
      skid_valid_d = 1'b0;
    end else if (drain_s) begin
      main_valid_d = accept_s;
      if (accept_s) begin
        main_data_d = in_data;
      end else begin
        main_data_d = main_data_q;
      end
    end else if (accept_s) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end else begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
    end
  end

  // Post-edge valid count, so the top can register occupancy in step with state.
  always_comb begin
    cnt_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  // Stage state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= FLUSH_VAL;
      skid_data_q  <= FLUSH_VAL;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// DEPTH skid stages in series with a registered occupancy count.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] FLUSH_VAL = {WIDTH{DEFAULT_FLUSH_BIT}},
  localparam int              OCC_W     = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH:0]   valid_s;
  logic [DEPTH:0]   ready_s;
  logic [WIDTH-1:0] data_s [DEPTH+1];
  logic [1:0]       cnt_d  [DEPTH];
  logic [OCC_W-1:0] occupancy_q, occupancy_d;

  assign valid_s[0]     = in_valid;
  assign data_s[0]      = in_data;
  assign ready_s[DEPTH] = out_ready;
  assign in_ready       = ready_s[0];
  assign out_valid      = valid_s[DEPTH];
  assign out_data       = data_s[DEPTH];
  assign occupancy      = occupancy_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    skid_stage #(
      .WIDTH    (WIDTH),
      .FLUSH_VAL(FLUSH_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (valid_s[k]),
      .in_ready (ready_s[k]),
      .in_data  (data_s[k]),
      .out_valid(valid_s[k+1]),
      .out_ready(ready_s[k+1]),
      .out_data (data_s[k+1]),
      .cnt_d    (cnt_d[k])
    );
  end

  // Sum of every stage's next valid count.
  always_comb begin
    occupancy_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy_d = occupancy_d + OCC_W'(cnt_d[k]);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed bench for elastic_pipe: DEPTH=2/WIDTH=32 main instance plus a
// DEPTH=1/WIDTH=8 instance, with a queue scoreboard for ordering.
module tb_elastic_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_data, out_data;
  logic [2:0]  occupancy;

  logic        b_in_valid, b_out_ready;
  logic        b_in_ready, b_out_valid;
  logic [7:0]  b_in_data, b_out_data;
  logic [1:0]  b_occupancy;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  elastic_pipe #(.WIDTH(32), .DEPTH(2), .FLUSH_VAL(32'hDEAD_BEEF)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  elastic_pipe #(.WIDTH(8), .DEPTH(1), .FLUSH_VAL(8'h5A)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the main instance: score the transfers about to happen, then
  // advance to the next falling edge and check occupancy against the model.
  task automatic step_a();
    logic [31:0] exp;
    logic        push, pop;
    push = in_valid && in_ready;
    pop  = out_valid && out_ready;
    if (pop) begin
      chk("pop_nonempty", {31'd0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        exp = q.pop_front();
        chk("pop_data", out_data, exp);
      end
    end
    if (flush) q.delete();
    else if (push) q.push_back(in_data);
    @(posedge clk);
    @(negedge clk);
    chk("occupancy", {29'd0, occupancy}, q.size());
  endtask

  initial begin
    int          n, np;
    logic        acc, stall;
    logic [31:0] sd, nxt;

    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = 32'd0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = 8'd0;
    #12;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_occ", {29'd0, occupancy}, 32'd0);
    chk("rst_out_data", out_data, 32'hDEAD_BEEF);
    chk("rst_b_out_data", {24'd0, b_out_data}, 32'h5A);
    rst = 1'b0;
    @(negedge clk);

    // Streaming: first word after two edges, then one per cycle.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 32'(i);
      step_a();
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      if (i == 1) chk("stream_lat", {31'd0, out_valid}, 32'd0);
      else begin
        chk("stream_valid", {31'd0, out_valid}, 32'd1);
        chk("stream_data", out_data, 32'(i - 1));
        chk("stream_occ", {29'd0, occupancy}, 32'd2);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step_a();
    chk("stream_empty", {31'd0, out_valid}, 32'd0);

    // Full backpressure: only four of six words fit.
    out_ready = 1'b0; in_valid = 1'b1; n = 0;
    for (int i = 0; i < 6; i++) begin
      in_data = 32'hA0 + 32'(n);
      acc = in_ready;
      step_a();
      if (acc) n++;
    end
    chk("bp_accepted", 32'(n), 32'd4);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_occ", {29'd0, occupancy}, 32'd4);
    out_ready = 1'b1; np = 0;
    for (int i = 0; i < 12; i++) begin
      if (n == 6) in_valid = 1'b0;
      else in_data = 32'hA0 + 32'(n);
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk("bp_order", out_data, 32'hA0 + 32'(np));
        np++;
      end
      step_a();
      if (acc) n++;
    end
    chk("bp_popped", 32'(np), 32'd6);

    // Flush with a same-cycle input word that must be dropped.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h31 + 32'(i);
      step_a();
    end
    chk("fl_pre_occ", {29'd0, occupancy}, 32'd3);
    flush = 1'b1; in_data = 32'h55;
    step_a();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_occ", {29'd0, occupancy}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_a();
      chk("fl_no_55", {31'd0, out_valid}, 32'd0);
    end

    // Asynchronous reset between edges with four words held.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h41 + 32'(i);
      step_a();
    end
    in_valid = 1'b0;
    chk("mr_pre_occ", {29'd0, occupancy}, 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_out_data", out_data, 32'hDEAD_BEEF);
    chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mr_occ", {29'd0, occupancy}, 32'd0);
    #1 rst = 1'b0;
    q.delete();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h61 + 32'(i);
      step_a();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step_a();

    // Random valid/ready against the scoreboard.
    nxt = 32'h1000;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = nxt;
      end
      out_ready = 1'($urandom_range(0, 1));
      stall = out_valid && !out_ready;
      sd    = out_data;
      acc   = in_valid && in_ready;
      step_a();
      if (acc) nxt++;
      if (stall) begin
        chk("rnd_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("rnd_hold_data", out_data, sd);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step_a();
    chk("rnd_drained", 32'(q.size()), 32'd0);
    chk("rnd_out_valid", {31'd0, out_valid}, 32'd0);

    // DEPTH=1, WIDTH=8 instance.
    b_in_valid = 1'b1; b_in_data = 8'h11;
    @(posedge clk); @(negedge clk);
    b_in_data = 8'h22;
    @(posedge clk); @(negedge clk);
    b_in_valid = 1'b0;
    chk("b_in_ready", {31'd0, b_in_ready}, 32'd0);
    chk("b_occ_full", {30'd0, b_occupancy}, 32'd2);
    chk("b_head", {24'd0, b_out_data}, 32'h11);
    b_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("b_second_valid", {31'd0, b_out_valid}, 32'd1);
    chk("b_second", {24'd0, b_out_data}, 32'h22);
    chk("b_occ_one", {30'd0, b_occupancy}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("b_empty", {31'd0, b_out_valid}, 32'd0);
    chk("b_occ_zero", {30'd0, b_occupancy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
